btb_update_ctrl: RTL

- Sequences all writes into the branch target buffer / 2-bit counter array that sits beside IF.
- Resolved-branch updates from EX are queued in a small FIFO and retired one per cycle through the predictor's single write port. The controller performs the read-modify-write of the saturating counter itself.
- Also runs a full-table invalidate walk, on request or after reset, so the predictor array needs no reset logic of its own.

---
 rtl/btb_update_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/btb_update_ctrl.sv
// rtl/btb_update_ctrl.sv - BTB/counter write sequencer: update FIFO drain with counter RMW plus invalidate walk
module btb_update_ctrl #(
    parameter int         PC_W           = 8,
    parameter int         IDX_W          = 6,
    parameter int         DEPTH          = 4,
    parameter logic [1:0] CTR_INIT       = 2'b01,
    parameter bit         FLUSH_ON_RESET = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             upd_valid,
    input  logic [PC_W-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic [PC_W-1:0]  upd_target,
    output logic             upd_ready,
    input  logic             flush_req,
    output logic [IDX_W-1:0] rd_index,
    input  logic [1:0]       rd_ctr,
    output logic             wr_en,
    output logic [IDX_W-1:0] wr_index,
    output logic [PC_W-1:0]  wr_target,
    output logic [1:0]       wr_ctr,
    output logic             busy,
    output logic             flush_done,
    output logic [7:0]       drop_cnt
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;
    localparam state_t RESET_STATE = FLUSH_ON_RESET ? FLUSH : IDLE;

    state_t           state;
    logic [IDX_W-1:0] walk_idx;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_next;

    logic [IDX_W-1:0] fifo_idx   [DEPTH];
    logic             fifo_taken [DEPTH];
    logic [PC_W-1:0]  fifo_tgt   [DEPTH];

    logic [IDX_W-1:0] wr_index_q;
    logic [PC_W-1:0]  wr_target_q;
    logic [1:0]       wr_ctr_q;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic unused_pc;

    function automatic logic [1:0] sat_ctr(input logic [1:0] ctr, input logic taken);
        if (taken)
            return (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        else
            return (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
    endfunction

    assign unused_pc = ^upd_pc;
    assign full      = (count == (PTR_W+1)'(DEPTH));
    assign empty     = (count == '0);
    assign upd_ready = !full && (state != FLUSH) && !flush_req;
    assign push      = upd_valid && upd_ready;
    assign pop       = (state == DRAIN) && !stall && !empty;
    assign busy      = (state != IDLE) || !empty;

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + 1'b1;
        else if (!push && pop)
            count_next = count - 1'b1;
    end

    // Write port is combinational so a drain read sees the previous edge's commit;
    // rst_n gating keeps the strobe quiet while reset holds the FSM in FLUSH.
    always_comb begin
        rd_index  = '0;
        wr_en     = 1'b0;
        wr_index  = wr_index_q;
        wr_target = wr_target_q;
        wr_ctr    = wr_ctr_q;
        if (state == DRAIN)
            rd_index = fifo_idx[rd_ptr];
        if (pop) begin
            wr_en     = 1'b1;
            wr_index  = fifo_idx[rd_ptr];
            wr_target = fifo_tgt[rd_ptr];
            wr_ctr    = sat_ctr(rd_ctr, fifo_taken[rd_ptr]);
        end else if ((state == FLUSH) && rst_n) begin
            wr_en     = 1'b1;
            wr_index  = walk_idx;
            wr_target = '0;
            wr_ctr    = CTR_INIT;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_idx[wr_ptr]   <= upd_pc[IDX_W+1:2];
            fifo_taken[wr_ptr] <= upd_taken;
            fifo_tgt[wr_ptr]   <= upd_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RESET_STATE;
            walk_idx    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            flush_done  <= 1'b0;
            wr_index_q  <= '0;
            wr_target_q <= '0;
            wr_ctr_q    <= '0;
        end else begin
            flush_done <= 1'b0;
            if (wr_en) begin
                wr_index_q  <= wr_index;
                wr_target_q <= wr_target;
                wr_ctr_q    <= wr_ctr;
            end
            if (flush_req) begin
                // (Re)start the walk; queued updates are discarded.
                state    <= FLUSH;
                walk_idx <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                count <= count_next;
                if (state == FLUSH) begin
                    walk_idx <= walk_idx + 1'b1;
                    if (walk_idx == '1) begin
                        state      <= IDLE;
                        flush_done <= 1'b1;
                    end
                end else begin
                    state <= (count_next != '0) ? DRAIN : IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_cnt <= '0;
        else if (upd_valid && !upd_ready && (drop_cnt != 8'hFF))
            drop_cnt <= drop_cnt + 8'd1;
    end
endmodule
